instr_fetch_unit: RTL and testbench

Instruction fetch stage of the single-cycle CPU. Holds the program counter, requests instruction words from instruction memory over a req/ack handshake, and presents each fetched word to the decode stage with a valid/ready handshake. The decoder takes its opcode from `instr_o[31:26]`. The PC advances by 4, or redirects to the branch target, when decode accepts the current instruction.

---
 rtl/instr_fetch_unit.sv | 148 ++++++++++++++
 tb/tb_instr_fetch_unit.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : instr_fetch_unit
// Description : Instruction fetch stage. Holds the PC, fetches instruction
//               words over a req/ack memory handshake and hands each word to
//               decode over a valid/ready handshake. PC advances by 4 or
//               redirects to the branch target when decode accepts.
//               Optional feature macro: IFU_ALIGN_CHECK_EN (misaligned branch
//               target halts the unit and raises fault_o until reset).
// Revision    : 1.0 - initial release
// ============================================================================
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_ack_i,
  input  logic [31:0] imem_rdata_i,
  output logic [31:0] instr_o,
  output logic        instr_valid_o,
  input  logic        instr_ready_i,
  input  logic        branch_i,
  input  logic [31:0] branch_target_i,
  output logic [31:0] pc_o,
  output logic [31:0] pc_plus4_o,
  output logic        fault_o
);

`ifdef IFU_ALIGN_CHECK_EN
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_REQ   = 2'd1,
    S_VALID = 2'd2,
    S_HALT  = 2'd3
  } state_t;
`else
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_REQ   = 2'd1,
    S_VALID = 2'd2
  } state_t;
`endif

  state_t      r_state;
  logic [31:0] r_pc;
  logic [31:0] r_instr;
  logic        r_valid;
  logic        r_req;

  logic [31:0] w_pc_plus4;
  logic [31:0] w_target;
  logic [31:0] w_next_pc;

`ifdef IFU_ALIGN_CHECK_EN
  logic r_fault;
  logic w_misaligned;

  // Target is taken verbatim; a taken branch with nonzero low bits is a fault.
  assign w_target     = branch_target_i;
  assign w_misaligned = branch_i & (|branch_target_i[1:0]);
  assign fault_o      = r_fault;
`else
  logic w_unused_tgt_lsb;

  // Without alignment checking the low target bits are simply dropped.
  assign w_target         = {branch_target_i[31:2], 2'b00};
  assign w_unused_tgt_lsb = ^branch_target_i[1:0];
  assign fault_o          = 1'b0;
`endif

  // PC arithmetic wraps modulo 2^32 by construction of the 32-bit add.
  assign w_pc_plus4 = r_pc + 32'd4;
  assign w_next_pc  = branch_i ? w_target : w_pc_plus4;

  assign imem_req_o    = r_req;
  assign imem_addr_o   = r_pc;
  assign instr_o       = r_instr;
  assign instr_valid_o = r_valid;
  assign pc_o          = r_pc;
  assign pc_plus4_o    = w_pc_plus4;

  // Fetch FSM: all outputs registered so ack/rdata and ready never reach
  // instr_o or imem_req_o combinationally.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= S_IDLE;
      r_pc    <= RESET_PC;
      r_instr <= 32'd0;
      r_valid <= 1'b0;
      r_req   <= 1'b0;
`ifdef IFU_ALIGN_CHECK_EN
      r_fault <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          r_req   <= 1'b1;
          r_state <= S_REQ;
        end
        S_REQ: begin
          if (imem_ack_i) begin
            r_instr <= imem_rdata_i;
            r_valid <= 1'b1;
            r_req   <= 1'b0;
            r_state <= S_VALID;
          end
        end
        S_VALID: begin
          if (instr_ready_i) begin
            r_valid <= 1'b0;
`ifdef IFU_ALIGN_CHECK_EN
            if (w_misaligned) begin
              r_pc    <= branch_target_i;
              r_fault <= 1'b1;
              r_req   <= 1'b0;
              r_state <= S_HALT;
            end else begin
              r_pc    <= w_next_pc;
              r_req   <= 1'b1;
              r_state <= S_REQ;
            end
`else
            r_pc    <= w_next_pc;
            r_req   <= 1'b1;
            r_state <= S_REQ;
`endif
          end
        end
`ifdef IFU_ALIGN_CHECK_EN
        S_HALT: begin
          r_req   <= 1'b0;
          r_valid <= 1'b0;
          r_fault <= 1'b1;
        end
`endif
        default: begin
          r_req   <= 1'b0;
          r_valid <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_instr_fetch_unit
// Description : Self-checking bench for instr_fetch_unit. Expected {pc, word}
//               pairs are queued when an ack is driven and popped when the
//               DUT presents the instruction to decode.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_instr_fetch_unit;

  logic        clk_i;
  logic        rst_i;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_ack_i;
  logic [31:0] imem_rdata_i;
  logic [31:0] instr_o;
  logic        instr_valid_o;
  logic        instr_ready_i;
  logic        branch_i;
  logic [31:0] branch_target_i;
  logic [31:0] pc_o;
  logic [31:0] pc_plus4_o;
  logic        fault_o;

  int total = 0;
  int bad   = 0;

  logic [63:0] sb_q[$];

  instr_fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .imem_req_o     (imem_req_o),
    .imem_addr_o    (imem_addr_o),
    .imem_ack_i     (imem_ack_i),
    .imem_rdata_i   (imem_rdata_i),
    .instr_o        (instr_o),
    .instr_valid_o  (instr_valid_o),
    .instr_ready_i  (instr_ready_i),
    .branch_i       (branch_i),
    .branch_target_i(branch_target_i),
    .pc_o           (pc_o),
    .pc_plus4_o     (pc_plus4_o),
    .fault_o        (fault_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  // Advance one rising edge; inputs are driven and outputs sampled 1 time unit after it.
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Stimulus only: ack the pending request with a word, then accept it sequentially.
  task automatic fetch_accept(input logic [31:0] word);
    imem_ack_i   = 1'b1;
    imem_rdata_i = word;
    tick();
    imem_ack_i    = 1'b0;
    instr_ready_i = 1'b1;
    tick();
    instr_ready_i = 1'b0;
  endtask

  // Ack the request in the current cycle and record the expected presentation.
  task automatic ack_push(input logic [31:0] word);
    imem_ack_i   = 1'b1;
    imem_rdata_i = word;
    sb_q.push_back({pc_o, word});
    tick();
    imem_ack_i = 1'b0;
  endtask

  task automatic test_reset();
    logic [63:0] exp;
    rst_i = 1'b1; imem_ack_i = 1'b0; imem_rdata_i = 32'd0;
    instr_ready_i = 1'b0; branch_i = 1'b0; branch_target_i = 32'd0;
    tick(); tick();
    total++;
    if ({imem_req_o, instr_valid_o, fault_o, instr_o, pc_o} !== {3'b000, 32'd0, 32'd0}) begin
      bad++;
      $display("FAIL reset_state: got req=%b valid=%b fault=%b instr=%h pc=%h, want all zero",
               imem_req_o, instr_valid_o, fault_o, instr_o, pc_o);
    end
    rst_i = 1'b0;
    #3;
    total++;
    if (imem_req_o !== 1'b0) begin
      bad++; $display("FAIL req_before_idle_edge: got %b want 0", imem_req_o);
    end
    tick();
    total++;
    if (imem_req_o !== 1'b1 || imem_addr_o !== 32'd0) begin
      bad++; $display("FAIL req_after_release: got req=%b addr=%h want 1/00000000", imem_req_o, imem_addr_o);
    end
    ack_push(32'h2010_0005);
    exp = sb_q.pop_front();
    total++;
    if (instr_valid_o !== 1'b1 || {pc_o, instr_o} !== exp || imem_req_o !== 1'b0) begin
      bad++; $display("FAIL first_fetch: got valid=%b pc=%h instr=%h req=%b want 1 %h %h 0",
                      instr_valid_o, pc_o, instr_o, imem_req_o, exp[63:32], exp[31:0]);
    end
    instr_ready_i = 1'b1;
    tick();
    instr_ready_i = 1'b0;
    total++;
    if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h4 || instr_valid_o !== 1'b0) begin
      bad++; $display("FAIL first_accept: got req=%b addr=%h valid=%b want 1 00000004 0",
                      imem_req_o, imem_addr_o, instr_valid_o);
    end
  endtask

  task automatic test_mem_wait();
    logic [63:0] exp;
    for (int i = 0; i < 3; i++) begin
      tick();
      total++;
      if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h4 || instr_valid_o !== 1'b0) begin
        bad++; $display("FAIL mem_wait_%0d: got req=%b addr=%h valid=%b want 1 00000004 0",
                        i, imem_req_o, imem_addr_o, instr_valid_o);
      end
    end
    ack_push(32'hA5A5_0001);
    exp = sb_q.pop_front();
    total++;
    if (instr_valid_o !== 1'b1 || {pc_o, instr_o} !== exp) begin
      bad++; $display("FAIL mem_wait_data: got valid=%b pc=%h instr=%h want 1 %h %h",
                      instr_valid_o, pc_o, instr_o, exp[63:32], exp[31:0]);
    end
    instr_ready_i = 1'b1;
    tick();
    instr_ready_i = 1'b0;
  endtask

  task automatic test_backpressure();
    logic [63:0] exp;
    fetch_accept(32'h1111_0008);
    fetch_accept(32'h1111_000C);
    total++;
    if (imem_addr_o !== 32'h10 || imem_req_o !== 1'b1) begin
      bad++; $display("FAIL seq_addr_10: got addr=%h req=%b want 00000010 1", imem_addr_o, imem_req_o);
    end
    ack_push(32'hDEAD_BEEF);
    exp = sb_q.pop_front();
    for (int i = 0; i < 4; i++) begin
      tick();
      total++;
      if (instr_valid_o !== 1'b1 || {pc_o, instr_o} !== exp || imem_req_o !== 1'b0) begin
        bad++; $display("FAIL backpressure_%0d: got valid=%b pc=%h instr=%h req=%b want 1 %h %h 0",
                        i, instr_valid_o, pc_o, instr_o, imem_req_o, exp[63:32], exp[31:0]);
      end
    end
    instr_ready_i = 1'b1;
    tick();
    instr_ready_i = 1'b0;
    total++;
    if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h14 || instr_valid_o !== 1'b0) begin
      bad++; $display("FAIL seq_after_stall: got req=%b addr=%h valid=%b want 1 00000014 0",
                      imem_req_o, imem_addr_o, instr_valid_o);
    end
  endtask

  task automatic test_branch();
    logic [63:0] exp;
    // Branch inputs present while fetching must be ignored.
    branch_i = 1'b1; branch_target_i = 32'h0000_0080;
    ack_push(32'h0BAD_0014);
    exp = sb_q.pop_front();
    total++;
    if ({pc_o, instr_o} !== exp) begin
      bad++; $display("FAIL branch_ignored_in_req: got pc=%h instr=%h want %h %h",
                      pc_o, instr_o, exp[63:32], exp[31:0]);
    end
    branch_target_i = 32'h0000_0040;
    instr_ready_i   = 1'b1;
    tick();
    instr_ready_i = 1'b0; branch_i = 1'b0; branch_target_i = 32'h1234_5678;
    total++;
    if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h40 || pc_plus4_o !== 32'h44) begin
      bad++; $display("FAIL taken_branch: got req=%b addr=%h pc4=%h want 1 00000040 00000044",
                      imem_req_o, imem_addr_o, pc_plus4_o);
    end
  endtask

  task automatic test_wrap_and_reset();
    imem_ack_i = 1'b1; imem_rdata_i = 32'h0000_0040;
    tick();
    imem_ack_i = 1'b0;
    instr_ready_i = 1'b1; branch_i = 1'b1; branch_target_i = 32'hFFFF_FFFC;
    tick();
    instr_ready_i = 1'b0; branch_i = 1'b0;
    total++;
    if (imem_addr_o !== 32'hFFFF_FFFC || pc_plus4_o !== 32'h0) begin
      bad++; $display("FAIL pc_plus4_wrap: got addr=%h pc4=%h want fffffffc 00000000", imem_addr_o, pc_plus4_o);
    end
    fetch_accept(32'hFFFF_0000);
    total++;
    if (pc_o !== 32'h0 || imem_req_o !== 1'b1) begin
      bad++; $display("FAIL pc_wrap: got pc=%h req=%b want 00000000 1", pc_o, imem_req_o);
    end
    fetch_accept(32'h0000_1000);
    // Reset together with an ack while requesting pc 4.
    rst_i = 1'b1; imem_ack_i = 1'b1; imem_rdata_i = 32'hCAFE_F00D;
    tick();
    rst_i = 1'b0;
    total++;
    if (instr_valid_o !== 1'b0 || imem_req_o !== 1'b0 || pc_o !== 32'h0 || instr_o !== 32'h0) begin
      bad++; $display("FAIL reset_mid_req: got valid=%b req=%b pc=%h instr=%h want 0 0 00000000 00000000",
                      instr_valid_o, imem_req_o, pc_o, instr_o);
    end
    // Late ack during the idle cycle must be ignored.
    tick();
    imem_ack_i = 1'b0;
    total++;
    if (instr_valid_o !== 1'b0 || imem_req_o !== 1'b1 || imem_addr_o !== 32'h0) begin
      bad++; $display("FAIL late_ack_ignored: got valid=%b req=%b addr=%h want 0 1 00000000",
                      instr_valid_o, imem_req_o, imem_addr_o);
    end
  endtask

  task automatic test_back_to_back();
    logic [63:0] exp;
    logic [31:0] pc_exp;
    pc_exp = pc_o;
    imem_ack_i = 1'b1; instr_ready_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      imem_rdata_i = 32'h5000_0000 + 32'(i);
      sb_q.push_back({pc_o, imem_rdata_i});
      tick();
      total++;
      if (sb_q.size() == 0) begin
        bad++; $display("FAIL b2b_queue_empty_%0d: got empty want entry", i);
      end else begin
        exp = sb_q.pop_front();
        if (instr_valid_o !== 1'b1 || {pc_o, instr_o} !== exp) begin
          bad++; $display("FAIL b2b_data_%0d: got valid=%b pc=%h instr=%h want 1 %h %h",
                          i, instr_valid_o, pc_o, instr_o, exp[63:32], exp[31:0]);
        end
      end
      tick();
      pc_exp = pc_exp + 32'd4;
      total++;
      if (imem_req_o !== 1'b1 || imem_addr_o !== pc_exp || instr_valid_o !== 1'b0) begin
        bad++; $display("FAIL b2b_req_%0d: got req=%b addr=%h valid=%b want 1 %h 0",
                        i, imem_req_o, imem_addr_o, instr_valid_o, pc_exp);
      end
    end
    imem_ack_i = 1'b0; instr_ready_i = 1'b0;
  endtask

  task automatic test_misaligned();
    imem_ack_i = 1'b1; imem_rdata_i = 32'h0000_0042;
    tick();
    imem_ack_i = 1'b0;
    instr_ready_i = 1'b1; branch_i = 1'b1; branch_target_i = 32'h0000_0042;
    tick();
    branch_i = 1'b0;
`ifdef IFU_ALIGN_CHECK_EN
    imem_ack_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      total++;
      if (fault_o !== 1'b1 || imem_req_o !== 1'b0 || instr_valid_o !== 1'b0 || pc_o !== 32'h42) begin
        bad++; $display("FAIL halt_%0d: got fault=%b req=%b valid=%b pc=%h want 1 0 0 00000042",
                        i, fault_o, imem_req_o, instr_valid_o, pc_o);
      end
    end
    imem_ack_i = 1'b0; instr_ready_i = 1'b0;
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    total++;
    if (fault_o !== 1'b0 || pc_o !== 32'h0) begin
      bad++; $display("FAIL halt_reset: got fault=%b pc=%h want 0 00000000", fault_o, pc_o);
    end
`else
    instr_ready_i = 1'b0;
    total++;
    if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h40 || fault_o !== 1'b0) begin
      bad++; $display("FAIL misaligned_forced: got req=%b addr=%h fault=%b want 1 00000040 0",
                      imem_req_o, imem_addr_o, fault_o);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_mem_wait();
    test_backpressure();
    test_branch();
    test_wrap_and_reset();
    test_back_to_back();
    test_misaligned();
    total++;
    if (sb_q.size() != 0) begin
      bad++; $display("FAIL scoreboard_drain: got %0d left want 0", sb_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
